// File: rtl/ysyx_041461_mul_issue_if.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_041461_mul_issue_if
// Purpose  : Bundles the three handshakes around the multiply issue unit:
//            EX-side op request, multiplier request/response, and the
//            writeback result channel.
// Modports : master - the issue unit (drives ex_ready, MUL_* requests, out_*)
//            slave  - the surroundings (EX pipe, multiplier, writeback)
// Revision : 1.0 - initial release
// ============================================================================
interface ysyx_041461_mul_issue_if;
  // EX pipeline side
  logic        ex_valid;
  logic        ex_ready;
  logic [2:0]  ex_op;
  logic [63:0] ex_src1;
  logic [63:0] ex_src2;
  logic        ex_flush;
  // Multiplier side
  logic        MUL_valid_in;
  logic        MUL_flush;
  logic        MUL_mulw;
  logic [1:0]  MUL_signed;
  logic [63:0] MUL_multiplicand;
  logic [63:0] MUL_multiplier;
  logic        MUL_ready;
  logic        MUL_valid_out;
  logic [63:0] MUL_result_hi;
  logic [63:0] MUL_result_lo;
  // Writeback side
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;

  modport master (
    input  ex_valid, ex_op, ex_src1, ex_src2, ex_flush,
    output ex_ready,
    output MUL_valid_in, MUL_flush, MUL_mulw, MUL_signed,
    output MUL_multiplicand, MUL_multiplier,
    input  MUL_ready, MUL_valid_out, MUL_result_hi, MUL_result_lo,
    output out_valid, out_data,
    input  out_ready
  );

  modport slave (
    output ex_valid, ex_op, ex_src1, ex_src2, ex_flush,
    input  ex_ready,
    input  MUL_valid_in, MUL_flush, MUL_mulw, MUL_signed,
    input  MUL_multiplicand, MUL_multiplier,
    output MUL_ready, MUL_valid_out, MUL_result_hi, MUL_result_lo,
    input  out_valid, out_data,
    output out_ready
  );
endinterface
`default_nettype wire

// File: rtl/ysyx_041461_mul_issue.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_041461_mul_issue
// Purpose  : EX-stage requester for the iterative multiplier. Accepts one
//            RV64M multiply op, issues it to the multiplier over a
//            valid/ready request, formats the returned 128-bit product into
//            the 64-bit writeback value and holds it until consumed. Flushes
//            from the pipeline are forwarded as a one-cycle MUL_flush pulse.
// Ports    : clk  - system clock, all state on rising edge
//            rst  - asynchronous active-low reset
//            bus  - ysyx_041461_mul_issue_if.master (EX, multiplier and
//                   writeback handshakes)
// Revision : 1.0 - initial release
// ============================================================================
module ysyx_041461_mul_issue (
  input  logic                           clk,
  input  logic                           rst,
  ysyx_041461_mul_issue_if.master        bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  state_e      state_q,    state_d;
  logic [63:0] mcand_q,    mcand_d;
  logic [63:0] mplier_q,   mplier_d;
  logic [63:0] out_data_q, out_data_d;
  logic [1:0]  signed_q,   signed_d;
  logic        mulw_q,     mulw_d;
  logic        sel_hi_q,   sel_hi_d;   // result comes from the upper half
  logic        flush_q,    flush_d;

  // Op decode; encodings 101-111 fall through to plain MUL.
  logic        dec_mulw;
  logic        dec_hi;
  logic [1:0]  dec_signed;
  logic [63:0] fmt_result;

  always_comb begin
    dec_mulw   = (bus.ex_op == 3'b100);
    dec_hi     = (bus.ex_op == 3'b001) || (bus.ex_op == 3'b010) ||
                 (bus.ex_op == 3'b011);
    case (bus.ex_op)
      3'b010:  dec_signed = 2'b10;  // MULHSU: signed rs1, unsigned rs2
      3'b011:  dec_signed = 2'b00;  // MULHU
      default: dec_signed = 2'b11;  // MUL, MULH, MULW
    endcase
  end

  // MULW takes the low word of the product and sign-extends it.
  always_comb begin
    if (mulw_q) begin
      fmt_result = {{32{bus.MUL_result_lo[31]}}, bus.MUL_result_lo[31:0]};
    end else if (sel_hi_q) begin
      fmt_result = bus.MUL_result_hi;
    end else begin
      fmt_result = bus.MUL_result_lo;
    end
  end

  // Next-state logic. Flush is tested first in every busy state so it
  // wins over a same-cycle handshake, result pulse or writeback consume.
  always_comb begin
    state_d    = state_q;
    mcand_d    = mcand_q;
    mplier_d   = mplier_q;
    out_data_d = out_data_q;
    signed_d   = signed_q;
    mulw_d     = mulw_q;
    sel_hi_d   = sel_hi_q;
    flush_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.ex_valid && !bus.ex_flush) begin
          mcand_d  = bus.ex_src1;
          mplier_d = bus.ex_src2;
          signed_d = dec_signed;
          mulw_d   = dec_mulw;
          sel_hi_d = dec_hi;
          state_d  = ST_REQ;
        end
      end
      ST_REQ: begin
        if (bus.ex_flush) begin
          flush_d = 1'b1;
          state_d = ST_IDLE;
        end else if (bus.MUL_ready) begin
          // MUL_valid_in is high for the whole of REQ, so ready alone
          // completes the handshake.
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (bus.ex_flush) begin
          flush_d = 1'b1;
          state_d = ST_IDLE;
        end else if (bus.MUL_valid_out) begin
          out_data_d = fmt_result;
          state_d    = ST_DONE;
        end
      end
      ST_DONE: begin
        // A flush here only drops the held result; the multiplier is
        // already idle, so no cancel pulse is sent.
        if (bus.ex_flush || bus.out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      mcand_q    <= 64'd0;
      mplier_q   <= 64'd0;
      out_data_q <= 64'd0;
      signed_q   <= 2'b00;
      mulw_q     <= 1'b0;
      sel_hi_q   <= 1'b0;
      flush_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      mcand_q    <= mcand_d;
      mplier_q   <= mplier_d;
      out_data_q <= out_data_d;
      signed_q   <= signed_d;
      mulw_q     <= mulw_d;
      sel_hi_q   <= sel_hi_d;
      flush_q    <= flush_d;
    end
  end

  // Every output is a flop or a pure decode of the state register.
  assign bus.ex_ready         = (state_q == ST_IDLE);
  assign bus.MUL_valid_in     = (state_q == ST_REQ);
  assign bus.MUL_flush        = flush_q;
  assign bus.MUL_mulw         = mulw_q;
  assign bus.MUL_signed       = signed_q;
  assign bus.MUL_multiplicand = mcand_q;
  assign bus.MUL_multiplier   = mplier_q;
  assign bus.out_valid        = (state_q == ST_DONE);
  assign bus.out_data         = out_data_q;

endmodule
`default_nettype wire
